// File: rtl/regmodel0_regmodel_core_reg_intf_reqissue_pkg.sv
// Shared types and field offsets for the regmodel0 register-interface request issuer.
package regmodel0_reqissue_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  // Response payload is {status[1:0], rdata[31:0]}.
  localparam int RSP_STATUS_LSB = 32;
  localparam int DATA_W         = 32;

  // Request payload is {write, addr[ADDR_W-1:0], wdata[31:0]}.
  function automatic int req_write_bit(input int addr_w);
    return addr_w + 32;
  endfunction

endpackage

// File: rtl/regmodel0_regmodel_core_reg_intf_reqissue_if.sv
// Host command, request, response and completion channels of the request issuer.
interface regmodel0_regmodel_core_reg_intf_reqissue_if #(
  parameter int ADDR_W = 16
);
  // Every channel is valid/ready: a transfer happens on a clock edge where both are high;
  // the sender keeps valid and its payload stable until that edge, ready may change freely.
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [31:0]       cmd_wdata_i;

  logic              req_valid_o;
  logic              req_ready_i;
  logic [ADDR_W+32:0] req_payload_o;

  logic              rsp_valid_i;
  logic              rsp_ready_o;
  logic [33:0]       rsp_payload_i;

  logic              done_valid_o;
  logic              done_ready_i;
  logic [31:0]       done_rdata_o;
  logic [1:0]        done_status_o;

  logic              clk_enable_o;

  // Core side of the channels.
  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    output cmd_ready_o,
    output req_valid_o, req_payload_o,
    input  req_ready_i,
    input  rsp_valid_i, rsp_payload_i,
    output rsp_ready_o,
    output done_valid_o, done_rdata_o, done_status_o,
    input  done_ready_i,
    output clk_enable_o
  );

  // Environment side: host, responder and clock-gate controller.
  modport master (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    input  cmd_ready_o,
    input  req_valid_o, req_payload_o,
    output req_ready_i,
    output rsp_valid_i, rsp_payload_i,
    input  rsp_ready_o,
    input  done_valid_o, done_rdata_o, done_status_o,
    output done_ready_i,
    input  clk_enable_o
  );
endinterface

// File: rtl/regmodel0_regmodel_core_reg_intf_reqissue_timeout_ctr.sv
// Response timeout counter: synchronous clear, count enable, saturates at LIMIT, flags LIMIT-1.
module regmodel0_reqissue_timeout_ctr #(
  parameter int LIMIT = 1024,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic payload_cgm_clk,
  input  logic hw_reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge payload_cgm_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != SAT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/regmodel0_regmodel_core_reg_intf_reqissue.sv
// Initiator end of the regmodel0 core register interface: one outstanding command at a time.
// Response timeout and stale-response draining exist only with REGMODEL0_REQISSUE_TIMEOUT_EN.
module regmodel0_regmodel_core_reg_intf_reqissue
  import regmodel0_reqissue_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic   payload_cgm_clk,
  input  logic   hw_reset_n,
  input  logic   func_reset_n,
  regmodel0_regmodel_core_reg_intf_reqissue_if.slave bus,
  output state_t dbg_state_o,
  output logic   dbg_stale_o
);
  localparam int PW     = ADDR_W + 33;
  localparam int WR_BIT = req_write_bit(ADDR_W);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t            state_q, state_d;
  logic              stale_q, stale_d;
  logic [PW-1:0]     req_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        status_q;
  logic              cmd_rdy_q, req_vld_q, rsp_rdy_q, done_vld_q;

  logic cmd_fire, req_fire, wait_rsp, timeout_hit, late_drop;

  assign cmd_fire = bus.cmd_valid_i && bus.cmd_ready_o;
  assign req_fire = (state_q == ST_REQ) && bus.req_ready_i;
  assign wait_rsp = (state_q == ST_WAIT) && bus.rsp_valid_i;

`ifdef REGMODEL0_REQISSUE_TIMEOUT_EN
  logic expired;

  regmodel0_reqissue_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .payload_cgm_clk (payload_cgm_clk),
    .hw_reset_n      (hw_reset_n),
    .clr             (!func_reset_n || req_fire),
    .en              (state_q == ST_WAIT),
    .expired         (expired)
  );

  // A response landing on the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q == ST_WAIT) && expired && !bus.rsp_valid_i;
  assign late_drop   = stale_q && bus.rsp_valid_i &&
                       (state_q != ST_WAIT) && (state_q != ST_INIT);
`else
  assign timeout_hit = 1'b0;
  assign late_drop   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: if (cmd_fire) state_d = ST_REQ;
      ST_REQ:  if (bus.req_ready_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.rsp_valid_i) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          stale_d = 1'b1;
        end
      end
      ST_DONE: if (bus.done_ready_i) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    if (late_drop) stale_d = 1'b0;
    if (!func_reset_n) begin
      state_d = ST_INIT;
      stale_d = 1'b0;
    end
  end

  // Handshake outputs are registered from the next state so they change only on clock edges.
  always_ff @(posedge payload_cgm_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      state_q    <= ST_INIT;
      stale_q    <= 1'b0;
      cmd_rdy_q  <= 1'b0;
      req_vld_q  <= 1'b0;
      rsp_rdy_q  <= 1'b0;
      done_vld_q <= 1'b0;
      req_q      <= '0;
      rdata_q    <= '0;
      status_q   <= STATUS_OK;
    end else begin
      state_q    <= state_d;
      stale_q    <= stale_d;
      cmd_rdy_q  <= (state_d == ST_IDLE) && !stale_d;
      req_vld_q  <= (state_d == ST_REQ);
      rsp_rdy_q  <= (state_d == ST_WAIT) || (stale_d && (state_d != ST_INIT));
      done_vld_q <= (state_d == ST_DONE);
      if (!func_reset_n) begin
        req_q    <= '0;
        rdata_q  <= '0;
        status_q <= STATUS_OK;
      end else begin
        if (cmd_fire) begin
          req_q[WR_BIT]              <= bus.cmd_write_i;
          req_q[WR_BIT-1 -: ADDR_W]  <= bus.cmd_addr_i;
          req_q[DATA_W-1:0]          <= bus.cmd_wdata_i;
        end
        if (wait_rsp) begin
          rdata_q  <= bus.rsp_payload_i[DATA_W-1:0];
          status_q <= bus.rsp_payload_i[RSP_STATUS_LSB +: 2];
        end else if (timeout_hit) begin
          rdata_q  <= '0;
          status_q <= STATUS_TIMEOUT;
        end
      end
    end
  end

  assign bus.cmd_ready_o   = cmd_rdy_q && func_reset_n;
  assign bus.req_valid_o   = req_vld_q;
  assign bus.req_payload_o = req_q;
  assign bus.rsp_ready_o   = rsp_rdy_q;
  assign bus.done_valid_o  = done_vld_q;
  assign bus.done_rdata_o  = rdata_q;
  assign bus.done_status_o = status_q;
  assign bus.clk_enable_o  = (state_q != ST_IDLE) || bus.cmd_valid_i ||
                             bus.rsp_valid_i || stale_q;

  assign dbg_state_o = state_q;
  assign dbg_stale_o = stale_q;

endmodule

// File: doc/regmodel0_regmodel_core_reg_intf_reqissue.md
Name: regmodel0_regmodel_core_reg_intf_reqissue

Overview:
- Initiator end of the regmodel0 core register interface.
- Accepts one host register command at a time and drives it onto the request channel as a valid/ready payload.
- Waits for the matching 34-bit response ({status[1:0], rdata[31:0]}), which arrives through the response buffer, and returns a completion to the host.
- Single outstanding transaction; optional response timeout; exports the clock enable the parent uses to gate payload_cgm_clk.

Parameters:
- ADDR_W, 16: register address width; request payload width = ADDR_W+33.
- TIMEOUT_CYCLES, 1024: cycles spent in WAIT before a timeout completion (>=2); counter width CNT_W = $clog2(TIMEOUT_CYCLES+1), local.

Ports:
- payload_cgm_clk  in  1  clock (gated by parent using clk_enable_o || !func_reset_n)
- hw_reset_n  in  1  reset, asynchronous, active-low
- func_reset_n  in  1  synchronous functional reset, active-low
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  host command accepted
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_W  register address
- cmd_wdata_i  in  32  write data, don't-care for reads
- req_valid_o  out  1  request valid
- req_ready_i  in  1  request ready
- req_payload_o  out  ADDR_W+33  {write, addr, wdata}
- rsp_valid_i  in  1  response valid, from response buffer
- rsp_ready_o  out  1  response ready
- rsp_payload_i  in  34  {status[1:0], rdata[31:0]}
- done_valid_o  out  1  completion valid
- done_ready_i  in  1  completion ready
- done_rdata_o  out  32  completion read data
- done_status_o  out  2  00 ok, 01/10 passed through from responder, 11 timeout
- clk_enable_o  out  1  clock-gate enable request

Behaviour:
- States: INIT(0), IDLE(1), REQ(2), WAIT(3), DONE(4); 3-bit encoding.
- hw_reset_n low (async), or func_reset_n low (sync): state=INIT, stale=0, counter=0, captured command and response registers=0.
- INIT -> IDLE unconditionally after one cycle. In INIT all handshake outputs are 0.
- Reset values: cmd_ready_o=0, req_valid_o=0, rsp_ready_o=0, done_valid_o=0, done_rdata_o=0, done_status_o=0, req_payload_o=0, clk_enable_o=1.
- cmd_ready_o = (state==IDLE) && !stale && func_reset_n.
- IDLE, cmd_valid_i && cmd_ready_o: capture {write, addr, wdata}, go to REQ.
- REQ: req_valid_o=1 with the captured payload held stable. On req_ready_i go to WAIT; counter cleared. Earliest req_valid_o is the cycle after command acceptance.
- WAIT:
  - rsp_ready_o=1; counter increments each cycle.
  - rsp_valid_i: capture rdata and status, go to DONE.
  - If rsp_valid_i and timeout expiry (counter==TIMEOUT_CYCLES-1) coincide, the response wins.
  - Timeout: done_rdata_o=0, done_status_o=2'b11, stale=1, go to DONE.
- DONE: done_valid_o=1 with data/status held stable. On done_ready_i go to IDLE.
- stale=1 (late response expected):
  - rsp_ready_o=1 in every state except INIT.
  - The first rsp_valid_i handshake outside WAIT is dropped and clears stale.
  - New commands are blocked until stale clears; only func_reset_n recovers a responder that never answers.
- rsp_ready_o=0 otherwise. A response arriving in IDLE/REQ/DONE with stale=0 is a protocol error: not accepted, left stalled.
- clk_enable_o = (state!=IDLE) || cmd_valid_i || rsp_valid_i || stale.
- Counter saturates and never wraps.

Optional Feature:
- REGMODEL0_REQISSUE_TIMEOUT_EN defined: timeout counter, stale flag and status 11 are implemented as above.
- Undefined: no counter or stale logic. WAIT exits only on rsp_valid_i. rsp_ready_o=(state==WAIT). done_status_o is never 11 unless the responder returns 11.

Decomposition:
- Package regmodel0_reqissue_pkg: state enum, STATUS_OK=2'b00, STATUS_TIMEOUT=2'b11, payload field offset constants (RSP_STATUS_LSB=32, REQ_WRITE_BIT=ADDR_W+32).
- One sub-module, regmodel0_reqissue_timeout_ctr: clear/enable/saturate counter plus expiry flag; instantiated only under the macro.

Test Plan:
- Read ok: cmd addr=0x0040, read, req_ready_i=1 immediately; rsp 3 cycles later {00, 0xDEADBEEF} -> req_payload_o={0, 0x0040, x}; done_rdata_o=0xDEADBEEF, status 00; cmd_ready_o high again the cycle after done handshake.
- Write with backpressure: req_ready_i low 5 cycles -> req_valid_o held 6 cycles, payload stable; done status 01 passed through from responder.
- Timeout (TIMEOUT_CYCLES=8, macro on): no response -> DONE after 8 WAIT cycles, status 11, rdata 0; cmd_ready_o stays 0 until a late rsp is drained; that rsp never appears on done.
- Race: rsp_valid_i on exactly the expiry cycle -> status from response, stale stays 0.
- func_reset_n low mid-WAIT -> INIT next edge, then IDLE; no done_valid_o; stale=0. hw_reset_n pulsed asynchronously in REQ -> req_valid_o drops immediately.
- Done backpressure: done_ready_i low 10 cycles -> done_valid_o, done_rdata_o and done_status_o held; cmd_ready_o stays 0.
